// File: rtl/c499_key_loader.sv
// Serial key loader for the key-gated c499: collects KEY_W key bits plus an
// even-parity bit and presents the key on key_out only after a clean frame.
module c499_key_loader #(
  parameter int               KEY_W        = 2,
  parameter bit               ALLOW_RELOAD = 1'b0,
  parameter logic [KEY_W-1:0] RESET_KEY    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_valid,
  input  logic             key_bit,
  output logic             key_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_locked,
  output logic             busy,
  output logic             err
);

  localparam int               CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(KEY_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY, LOCKED} state_t;

  state_t           state;
  logic [KEY_W-1:0] shadow;
  logic [CNT_W-1:0] cnt;
  logic             xfer;

  assign xfer = key_valid & key_ready;

  // Even parity across key and parity bit: the parity bit must equal the key XOR.
  function automatic logic parity_ok(input logic [KEY_W-1:0] k, input logic p);
    return (^k) == p;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shadow     <= '0;
      cnt        <= '0;
      key_out    <= RESET_KEY;
      key_locked <= 1'b0;
      key_ready  <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= SHIFT;
            cnt       <= '0;
            shadow    <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        SHIFT, PARITY: begin
          // A start mid-frame wins over any bit offered in the same cycle.
          if (start) begin
            state  <= SHIFT;
            cnt    <= '0;
            shadow <= '0;
          end else if (xfer) begin
            if (state == SHIFT) begin
              for (int i = 0; i < KEY_W; i++) begin
                if (cnt == CNT_W'(i)) shadow[i] <= key_bit;
              end
              cnt <= cnt + CNT_W'(1);
              if (cnt == LAST) state <= PARITY;
            end else begin
              key_ready <= 1'b0;
              busy      <= 1'b0;
              if (parity_ok(shadow, key_bit)) begin
                key_out    <= shadow;
                key_locked <= 1'b1;
                state      <= LOCKED;
              end else begin
                err   <= 1'b1;
                state <= IDLE;
              end
            end
          end
        end
        LOCKED: begin
          // The old key stays on key_out until a reload frame verifies.
          if (start && ALLOW_RELOAD) begin
            state     <= SHIFT;
            cnt       <= '0;
            shadow    <= '0;
            key_ready <= 1'b1;
            busy      <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_c499_key_loader.sv
// Bench for c499_key_loader: a sticky instance and a reloadable instance share
// the stimulus and are compared against a frame-level reference model.
module tb_c499_key_loader;

  localparam int         KW     = 2;
  localparam logic [1:0] RK [2] = '{2'b00, 2'b11};
  localparam bit         RL [2] = '{1'b0, 1'b1};

  logic       clk = 1'b0;
  logic       rst = 1'b0, start = 1'b0, key_valid = 1'b0, key_bit = 1'b0;
  logic [1:0] d_out  [2];
  logic       d_rdy  [2];
  logic       d_lock [2];
  logic       d_busy [2];
  logic       d_err  [2];

  int checks = 0;
  int errors = 0;

  // Reference model: a frame is open/closed, bits are gathered in a queue and
  // judged once KW+1 of them have arrived.
  bit         m_act  [2];
  bit         m_hold [2];
  bit         m_lock [2];
  bit         m_err  [2];
  logic [1:0] m_key  [2];
  bit         mq     [2][$];

  always #5 clk = ~clk;

  c499_key_loader #(.KEY_W(KW), .ALLOW_RELOAD(1'b0), .RESET_KEY(2'b00)) dut0 (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_bit(key_bit),
    .key_ready(d_rdy[0]), .key_out(d_out[0]), .key_locked(d_lock[0]),
    .busy(d_busy[0]), .err(d_err[0]));

  c499_key_loader #(.KEY_W(KW), .ALLOW_RELOAD(1'b1), .RESET_KEY(2'b11)) dut1 (
    .clk(clk), .rst(rst), .start(start), .key_valid(key_valid), .key_bit(key_bit),
    .key_ready(d_rdy[1]), .key_out(d_out[1]), .key_locked(d_lock[1]),
    .busy(d_busy[1]), .err(d_err[1]));

  function automatic void model_step(int k, logic r, logic s, logic v, logic b);
    int ones;
    m_err[k] = 1'b0;
    if (r) begin
      m_act[k] = 1'b0; m_hold[k] = 1'b0; m_lock[k] = 1'b0; m_key[k] = RK[k];
      mq[k].delete();
    end else if (s && (m_act[k] || !m_hold[k] || RL[k])) begin
      m_act[k] = 1'b1; m_hold[k] = 1'b0;
      mq[k].delete();
    end else if (v && m_act[k]) begin
      mq[k].push_back(b);
      if (mq[k].size() == KW + 1) begin
        ones = 0;
        for (int i = 0; i <= KW; i++) ones += int'(mq[k][i]);
        if (ones % 2 == 0) begin
          for (int i = 0; i < KW; i++) m_key[k][i] = mq[k][i];
          m_lock[k] = 1'b1; m_hold[k] = 1'b1;
        end else begin
          m_err[k] = 1'b1;
        end
        m_act[k] = 1'b0;
        mq[k].delete();
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic s, input logic v, input logic b);
    rst = r; start = s; key_valid = v; key_bit = b;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k, r, s, v, b);
    #1;
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0000}) begin
        errors++;
        $display("FAIL reset dut%0d: out/lock/rdy/busy/err got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0000});
      end
    end
  endtask

  task automatic test_lock();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0110}) begin
        errors++;
        $display("FAIL lock_midframe dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0110});
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== 6'b01_1000) begin
        errors++;
        $display("FAIL lock_done dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, 6'b01_1000);
      end
    end
  endtask

  task automatic test_reload();
    logic [5:0] want;
    logic [3:0] bits;
    bits = 4'b1100;
    for (int step = 0; step < 4; step++) begin
      cyc(1'b0, step == 0, step > 0, bits[step]);
      for (int k = 0; k < 2; k++) begin
        if (k == 0)      want = 6'b01_1000;
        else if (step < 3) want = 6'b01_1110;
        else             want = 6'b10_1000;
        checks++;
        if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== want) begin
          errors++;
          $display("FAIL reload step%0d dut%0d: got %b want %b", step, k,
                   {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, want);
        end
      end
    end
  endtask

  task automatic test_parity_err();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0001}) begin
        errors++;
        $display("FAIL parity_err_pulse dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0001});
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0000}) begin
        errors++;
        $display("FAIL parity_err_after dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0000});
      end
    end
  endtask

  task automatic test_gaps_and_restart();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0110}) begin
        errors++;
        $display("FAIL gap_stall dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0110});
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== 6'b01_1000) begin
        errors++;
        $display("FAIL gap_lock dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, 6'b01_1000);
      end
    end
    // Restart mid-frame with a simultaneous bit, then start+valid in IDLE.
    for (int pass = 0; pass < 2; pass++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      if (pass == 0) begin
        cyc(1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
      end
      cyc(1'b0, 1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== 6'b10_1000) begin
          errors++;
          $display("FAIL start_drop pass%0d dut%0d: got %b want %b", pass, k,
                   {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, 6'b10_1000);
        end
      end
    end
  endtask

  task automatic test_reset_in_parity();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== {RK[k], 4'b0000}) begin
        errors++;
        $display("FAIL reset_in_parity dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, {RK[k], 4'b0000});
      end
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]} !== 6'b10_1000) begin
        errors++;
        $display("FAIL relock_after_reset dut%0d: got %b want %b", k,
                 {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]}, 6'b10_1000);
      end
    end
  endtask

  task automatic test_random();
    logic [5:0] got, want;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int n = 0; n < 800; n++) begin
      cyc($urandom_range(0, 59) == 0, $urandom_range(0, 9) == 0,
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        got  = {d_out[k], d_lock[k], d_rdy[k], d_busy[k], d_err[k]};
        want = {m_key[k], m_lock[k], m_act[k], m_act[k], m_err[k]};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL random cycle%0d dut%0d: out/lock/rdy/busy/err got %b want %b",
                   n, k, got, want);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0; m_hold[k] = 1'b0; m_lock[k] = 1'b0; m_err[k] = 1'b0;
      m_key[k] = RK[k];
    end
    test_reset();
    test_lock();
    test_reload();
    test_parity_err();
    test_gaps_and_restart();
    test_reset_in_parity();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
